// File: rtl/tx_symbol_sched_if.sv
// Scheduler port bundle: upstream packet stream, control levels and encoder-side outputs.
// master drives the stream and control inputs; slave is the scheduler itself.
interface tx_symbol_sched_if;
  logic        tx_en;
  logic        train_req;
  logic [7:0]  s_data;
  logic        s_datak;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  txdata;
  logic        txdatak;
  logic        enc_en_n;
  logic [1:0]  sched_state;
  logic [15:0] ts_cnt;

  modport master (
    output tx_en, train_req, s_data, s_datak, s_valid, s_last,
    input  s_ready, txdata, txdatak, enc_en_n, sched_state, ts_cnt
  );

  modport slave (
    input  tx_en, train_req, s_data, s_datak, s_valid, s_last,
    output s_ready, txdata, txdatak, enc_en_n, sched_state, ts_cnt
  );
endinterface

// File: rtl/tx_symbol_sched.sv
// Shares the 8b/10b encoder input between packets, SKP ordered sets and training sets; one
// registered symbol per clock, 1-cycle latency; s_ready drops while SKP/training owns the encoder.
module tx_symbol_sched #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3,
  parameter int unsigned TS_LEN       = 16
) (
  input  logic             clk,
  input  logic             reset,
  tx_symbol_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_SKP   = 2'd2,
    ST_TRAIN = 2'd3
  } state_e;

  localparam int unsigned   TW         = $clog2(SKP_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SKP_INTERVAL - 1);
  localparam logic [5:0]    SKP_LAST   = 6'(SKP_COUNT - 1);
  localparam logic [5:0]    TS_LAST    = 6'(TS_LEN - 2);

  localparam logic [7:0] SYM_IDLE = 8'h00;
  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] SYM_PAD  = 8'hF7;
  localparam logic [7:0] SYM_TS   = 8'h4A;

  // ctl_q is the controller state; it is already IDLE while the last symbol of a
  // sequence is on txdata, so the next sequence can be chosen with no gap.
  // sched_q labels the symbol currently on txdata.
  state_e        ctl_q, ctl_d;
  state_e        sched_q, sched_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [7:0]    txdata_q, txdata_d;
  logic          txdatak_q, txdatak_d;
  logic          enc_en_n_q, enc_en_n_d;
  logic [15:0]   ts_cnt_q, ts_cnt_d;
  logic          s_ready;
  logic          beat;
  logic          pending_clr;

  always_comb begin
    s_ready = 1'b0;
    if (bus.tx_en && !reset) begin
      case (ctl_q)
        ST_IDLE: s_ready = !pending_q && !bus.train_req;
        ST_DATA: s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign beat = bus.s_valid && s_ready;

  always_comb begin
    ctl_d       = ctl_q;
    sched_d     = sched_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    pending_d   = pending_q;
    txdata_d    = SYM_IDLE;
    txdatak_d   = 1'b0;
    enc_en_n_d  = !bus.tx_en;
    ts_cnt_d    = ts_cnt_q;
    pending_clr = 1'b0;

    if (!bus.tx_en) begin
      ctl_d     = ST_IDLE;
      sched_d   = ST_IDLE;
      cnt_d     = '0;
      timer_d   = '0;
      pending_d = 1'b0;
    end else begin
      case (ctl_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pending_q) begin
            txdata_d    = SYM_COM;
            txdatak_d   = 1'b1;
            ctl_d       = ST_SKP;
            sched_d     = ST_SKP;
            pending_clr = 1'b1;
          end else if (bus.train_req) begin
            txdata_d  = SYM_COM;
            txdatak_d = 1'b1;
            ctl_d     = ST_TRAIN;
            sched_d   = ST_TRAIN;
          end else if (beat) begin
            txdata_d  = bus.s_data;
            txdatak_d = bus.s_datak;
            sched_d   = ST_DATA;
            ctl_d     = bus.s_last ? ST_IDLE : ST_DATA;
          end else begin
            sched_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          sched_d = ST_DATA;
          if (beat) begin
            txdata_d  = bus.s_data;
            txdatak_d = bus.s_datak;
            if (bus.s_last) ctl_d = ST_IDLE;
          end else begin
            txdata_d  = SYM_PAD;
            txdatak_d = 1'b1;
          end
        end
        ST_SKP: begin
          txdata_d  = SYM_SKP;
          txdatak_d = 1'b1;
          sched_d   = ST_SKP;
          cnt_d     = cnt_q + 6'd1;
          if (cnt_q == SKP_LAST) ctl_d = ST_IDLE;
        end
        ST_TRAIN: begin
          txdata_d = SYM_TS;
          sched_d  = ST_TRAIN;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == TS_LAST) begin
            ctl_d = ST_IDLE;
            if (ts_cnt_q != 16'hFFFF) ts_cnt_d = ts_cnt_q + 16'd1;
          end
        end
      endcase

      // A fresh expiry wins over the clear so a request is never lost.
      if (timer_q == TIMER_LAST) begin
        timer_d   = '0;
        pending_d = 1'b1;
      end else begin
        timer_d   = timer_q + TW'(1);
        pending_d = pending_q && !pending_clr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q      <= ST_IDLE;
      sched_q    <= ST_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      txdata_q   <= SYM_IDLE;
      txdatak_q  <= 1'b0;
      enc_en_n_q <= 1'b1;
      ts_cnt_q   <= '0;
    end else begin
      ctl_q      <= ctl_d;
      sched_q    <= sched_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      txdata_q   <= txdata_d;
      txdatak_q  <= txdatak_d;
      enc_en_n_q <= enc_en_n_d;
      ts_cnt_q   <= ts_cnt_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.txdata      = txdata_q;
  assign bus.txdatak     = txdatak_q;
  assign bus.enc_en_n    = enc_en_n_q;
  assign bus.sched_state = sched_q;
  assign bus.ts_cnt      = ts_cnt_q;

endmodule

// File: tb/tb_tx_symbol_sched.sv
// Directed bench for tx_symbol_sched with SKP_INTERVAL=16, SKP_COUNT=3, TS_LEN=4.
module tb_tx_symbol_sched;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_SKP   = 2'd2;
  localparam logic [1:0] S_TRAIN = 2'd3;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  tx_symbol_sched_if bus ();

  tx_symbol_sched #(
    .SKP_INTERVAL(16),
    .SKP_COUNT   (3),
    .TS_LEN      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic k,
                         input logic en_n, input logic [1:0] st);
    chk(tag, {20'h0, bus.txdata, bus.txdatak, bus.enc_en_n, bus.sched_state},
             {20'h0, d, k, en_n, st});
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    #1;
    chk(tag, {31'h0, bus.s_ready}, {31'h0, exp});
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_datak = 1'b0;
    bus.s_last  = last;
  endtask

  // One disabled cycle clears the SKP timer; returns in the first enabled cycle.
  task automatic restart();
    bus.tx_en = 1'b0;
    tick();
    chk_out("restart_disabled", 8'h00, 1'b0, 1'b1, S_IDLE);
    bus.tx_en = 1'b1;
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.tx_en     = 1'b0;
    bus.train_req = 1'b0;
    bus.s_data    = 8'h00;
    bus.s_datak   = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    tick();
    tick();
    chk_out("reset_out", 8'h00, 1'b0, 1'b1, S_IDLE);
    chk("reset_ts_cnt", {16'h0, bus.ts_cnt}, 32'h0);
    chk_rdy("reset_s_ready", 1'b0);
    reset = 1'b0;

    // Packet with a two-cycle bubble after 0x22
    restart();
    beat(8'h11, 1'b0);
    chk_rdy("pkt_rdy_idle", 1'b1);
    tick(); chk_out("pkt_11", 8'h11, 1'b0, 1'b0, S_DATA); beat(8'h22, 1'b0);
    tick(); chk_out("pkt_22", 8'h22, 1'b0, 1'b0, S_DATA); bus.s_valid = 1'b0;
    chk_rdy("pkt_rdy_data", 1'b1);
    tick(); chk_out("pkt_pad0", 8'hF7, 1'b1, 1'b0, S_DATA);
    tick(); chk_out("pkt_pad1", 8'hF7, 1'b1, 1'b0, S_DATA); beat(8'h33, 1'b1);
    tick(); chk_out("pkt_33", 8'h33, 1'b0, 1'b0, S_DATA);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    tick(); chk_out("pkt_idle", 8'h00, 1'b0, 1'b0, S_IDLE);

    // SKP expiry (pending from enabled cycle 16) lands mid-packet
    restart();
    repeat (13) tick();
    beat(8'hA1, 1'b0);
    tick(); chk_out("skpd_a1", 8'hA1, 1'b0, 1'b0, S_DATA); beat(8'hA2, 1'b0);
    tick(); chk_out("skpd_a2", 8'hA2, 1'b0, 1'b0, S_DATA); beat(8'hA3, 1'b0);
    tick(); chk_out("skpd_a3", 8'hA3, 1'b0, 1'b0, S_DATA); beat(8'hA4, 1'b0);
    chk_rdy("skpd_rdy_mid_pkt", 1'b1);
    tick(); chk_out("skpd_a4", 8'hA4, 1'b0, 1'b0, S_DATA); beat(8'hA5, 1'b1);
    tick(); chk_out("skpd_a5", 8'hA5, 1'b0, 1'b0, S_DATA); beat(8'h55, 1'b1);
    chk_rdy("skpd_rdy_pending", 1'b0);
    tick(); chk_out("skpd_com", 8'hBC, 1'b1, 1'b0, S_SKP);
    chk_rdy("skpd_rdy_com", 1'b0);
    tick(); chk_out("skpd_skp0", 8'h1C, 1'b1, 1'b0, S_SKP);
    chk_rdy("skpd_rdy_skp0", 1'b0);
    tick(); chk_out("skpd_skp1", 8'h1C, 1'b1, 1'b0, S_SKP);
    tick(); chk_out("skpd_skp2", 8'h1C, 1'b1, 1'b0, S_SKP);
    chk_rdy("skpd_rdy_last_skp", 1'b1);
    tick(); chk_out("skpd_held_beat", 8'h55, 1'b0, 1'b0, S_DATA); bus.s_valid = 1'b0;
    tick(); chk_out("skpd_idle", 8'h00, 1'b0, 1'b0, S_IDLE);

    // Training request beats a valid packet beat
    restart();
    bus.train_req = 1'b1;
    beat(8'h66, 1'b1);
    chk_rdy("pri_rdy_req", 1'b0);
    tick(); chk_out("pri_com", 8'hBC, 1'b1, 1'b0, S_TRAIN); bus.train_req = 1'b0;
    chk_rdy("pri_rdy_com", 1'b0);
    tick(); chk_out("pri_ts0", 8'h4A, 1'b0, 1'b0, S_TRAIN);
    chk_rdy("pri_rdy_ts0", 1'b0);
    tick(); chk_out("pri_ts1", 8'h4A, 1'b0, 1'b0, S_TRAIN);
    chk("pri_ts_cnt_before", {16'h0, bus.ts_cnt}, 32'd0);
    tick(); chk_out("pri_ts2", 8'h4A, 1'b0, 1'b0, S_TRAIN);
    chk("pri_ts_cnt_after", {16'h0, bus.ts_cnt}, 32'd1);
    chk_rdy("pri_rdy_set_done", 1'b1);
    tick(); chk_out("pri_beat", 8'h66, 1'b0, 1'b0, S_DATA); bus.s_valid = 1'b0;
    tick(); chk_out("pri_idle", 8'h00, 1'b0, 1'b0, S_IDLE);

    // SKP expiry and train_req at the same boundary
    restart();
    repeat (16) tick();
    bus.train_req = 1'b1;
    chk_out("sim_pre_idle", 8'h00, 1'b0, 1'b0, S_IDLE);
    chk_rdy("sim_rdy", 1'b0);
    tick(); chk_out("sim_com_skp", 8'hBC, 1'b1, 1'b0, S_SKP);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("sim_skp", 8'h1C, 1'b1, 1'b0, S_SKP);
    end
    tick(); chk_out("sim_com_ts", 8'hBC, 1'b1, 1'b0, S_TRAIN); bus.train_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("sim_ts", 8'h4A, 1'b0, 1'b0, S_TRAIN);
    end
    chk("sim_ts_cnt", {16'h0, bus.ts_cnt}, 32'd2);
    tick(); chk_out("sim_idle", 8'h00, 1'b0, 1'b0, S_IDLE);

    // Disable mid-packet, then re-enable restarts the SKP timer
    restart();
    beat(8'h77, 1'b0);
    tick(); chk_out("dis_77", 8'h77, 1'b0, 1'b0, S_DATA); beat(8'h78, 1'b0);
    tick(); chk_out("dis_78", 8'h78, 1'b0, 1'b0, S_DATA);
    bus.tx_en = 1'b0;
    beat(8'h79, 1'b0);
    chk_rdy("dis_rdy", 1'b0);
    tick(); chk_out("dis_out", 8'h00, 1'b0, 1'b1, S_IDLE);
    bus.s_valid = 1'b0;
    bus.tx_en   = 1'b1;
    tick(); chk_out("reen_en", 8'h00, 1'b0, 1'b0, S_IDLE);
    repeat (14) tick();
    chk_rdy("reen_rdy_before_expiry", 1'b1);
    tick(); chk_out("reen_idle_16", 8'h00, 1'b0, 1'b0, S_IDLE);
    chk_rdy("reen_rdy_pending", 1'b0);
    tick(); chk_out("reen_com", 8'hBC, 1'b1, 1'b0, S_SKP);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("reen_skp", 8'h1C, 1'b1, 1'b0, S_SKP);
    end
    bus.train_req = 1'b1;

    // Reset in the middle of a training set
    tick(); chk_out("rst_ts_com", 8'hBC, 1'b1, 1'b0, S_TRAIN);
    tick(); chk_out("rst_ts_body", 8'h4A, 1'b0, 1'b0, S_TRAIN);
    chk("rst_ts_cnt_before", {16'h0, bus.ts_cnt}, 32'd2);
    reset = 1'b1;
    #1;
    chk_out("rst_async_out", 8'h00, 1'b0, 1'b1, S_IDLE);
    chk("rst_async_ts_cnt", {16'h0, bus.ts_cnt}, 32'd0);
    chk_rdy("rst_rdy_req", 1'b0);
    bus.train_req = 1'b0;
    chk_rdy("rst_rdy_noreq", 1'b0);
    tick();
    chk_out("rst_held_out", 8'h00, 1'b0, 1'b1, S_IDLE);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
